// File: rtl/i2c_gain_slave.sv
// I2C target holding the AD9866 TX/RX gain registers, with readback and an ID byte.
// SCL/SDA are synchronised and glitch-filtered; all bus decoding uses the filtered levels.
module i2c_gain_slave #(
  parameter logic [6:0]  I2C_ADDR     = 7'h41,
  parameter int unsigned FILT         = 3,
  parameter logic [3:0]  TX_GAIN_INIT = 4'h0,
  parameter logic [5:0]  RX_GAIN_INIT = 6'h00,
  parameter logic [7:0]  ID_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [3:0] i2c_tx_gain_reg,
  output logic [5:0] i2c_rx_gain_reg,
  output logic       i2c_tx_gain_update_req,
  output logic       i2c_rx_gain_update_req
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

  logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rd_q, rd_d;
  logic [1:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic [3:0] tx_q, tx_d;
  logic [5:0] rx_q, rx_d;
  logic       tx_req_q, tx_req_d;
  logic       rx_req_q, rx_req_d;
  logic       sda_oe_q, sda_oe_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic [7:0] rd_first;

  function automatic logic [7:0] rd_map(input logic [1:0] p, input logic [3:0] tx,
                                        input logic [5:0] rx);
    logic [7:0] v;
    case (p)
      2'd0:    v = {4'h0, tx};
      2'd1:    v = {2'b00, rx};
      2'd2:    v = ID_BYTE;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Synchronisers and filters: a level flips only after FILT consecutive differing samples.
  always_comb begin
    scl_s1_d  = scl_i;
    scl_s2_d  = scl_s1_q;
    sda_s1_d  = sda_i;
    sda_s2_d  = sda_s1_q;
    scl_f_d   = scl_f_q;
    scl_cnt_d = 4'd0;
    sda_f_d   = sda_f_q;
    sda_cnt_d = 4'd0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == FILT_M1) scl_f_d = scl_s2_q;
      else                      scl_cnt_d = scl_cnt_q + 4'd1;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == FILT_M1) sda_f_d = sda_s2_q;
      else                      sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  assign scl_rise  = scl_f_d & ~scl_f_q;
  assign scl_fall  = ~scl_f_d & scl_f_q;
  assign start_det = ~sda_f_d & sda_f_q & scl_f_q & scl_f_d;
  assign stop_det  = sda_f_d & ~sda_f_q & scl_f_q & scl_f_d;
  assign byte_in   = {shift_q[6:0], sda_f_q};
  assign rd_first  = rd_map(ptr_q, tx_q, rx_q);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    tx_req_d  = 1'b0;
    rx_req_d  = 1'b0;
    sda_oe_d  = sda_oe_q;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_in[7:1] == I2C_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == REG) begin
                ptr_d   = byte_in[1:0];
                state_d = REG_ACK;
              end else begin
                case (ptr_q)
                  2'd0: begin tx_d = byte_in[3:0]; tx_req_d = 1'b1; end
                  2'd1: begin rx_d = byte_in[5:0]; rx_req_d = 1'b1; end
                  default: ;
                endcase
                ptr_d   = ptr_q + 2'd1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        // First fall after the byte asserts the ACK; the next fall ends the ACK slot.
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RDATA;
              bit_cnt_d = 3'd0;
              rd_d      = rd_first;
              sda_oe_d  = ~rd_first[7];
            end else begin
              state_d   = (state_q == ADDR_ACK) ? REG : WDATA;
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
          end else if (scl_fall) begin
            sda_oe_d = ~rd_q[3'd7 - bit_cnt_q];
          end
        end
        RDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_f_q) begin
              ptr_d     = ptr_q + 2'd1;
              rd_d      = rd_map(ptr_q + 2'd1, tx_q, rx_q);
              bit_cnt_d = 3'd0;
              state_d   = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_cnt_q <= 4'd0;
      sda_cnt_q <= 4'd0;
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      rd_q      <= 8'd0;
      ptr_q     <= 2'd0;
      rw_q      <= 1'b0;
      tx_q      <= TX_GAIN_INIT;
      rx_q      <= RX_GAIN_INIT;
      tx_req_q  <= 1'b0;
      rx_req_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      scl_s1_q  <= scl_s1_d;
      scl_s2_q  <= scl_s2_d;
      sda_s1_q  <= sda_s1_d;
      sda_s2_q  <= sda_s2_d;
      scl_f_q   <= scl_f_d;
      sda_f_q   <= sda_f_d;
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      tx_req_q  <= tx_req_d;
      rx_req_q  <= rx_req_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign sda_oe                 = sda_oe_q;
  assign i2c_tx_gain_reg        = tx_q;
  assign i2c_rx_gain_reg        = rx_q;
  assign i2c_tx_gain_update_req = tx_req_q;
  assign i2c_rx_gain_update_req = rx_req_q;

endmodule

// File: tb/tb_i2c_gain_slave.sv
// Bench for i2c_gain_slave: bit-banged I2C master with a register-map reference model.
module tb_i2c_gain_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe;
  logic [3:0] tx_gain;
  logic [5:0] rx_gain;
  logic       tx_req, rx_req;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_gain_slave dut (
    .clk                    (clk),
    .rst                    (rst),
    .scl_i                  (scl_m),
    .sda_i                  (sda_line),
    .sda_oe                 (sda_oe),
    .i2c_tx_gain_reg        (tx_gain),
    .i2c_rx_gain_reg        (rx_gain),
    .i2c_tx_gain_update_req (tx_req),
    .i2c_rx_gain_update_req (rx_req)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: register file seen through the pointer.
  int m_tx = 0, m_rx = 0, m_ptr = 0, exp_txp = 0, exp_rxp = 0;

  task automatic m_wr(input int d);
    if (m_ptr == 0) begin m_tx = d % 16; exp_txp++; end
    if (m_ptr == 1) begin m_rx = d % 64; exp_rxp++; end
    m_ptr = (m_ptr + 1) % 4;
  endtask

  function automatic int m_rd();
    if (m_ptr == 0) return m_tx;
    if (m_ptr == 1) return m_rx;
    if (m_ptr == 2) return 'hA5;
    return 0;
  endfunction

  // Monitor of output pulses and SDA drive.
  int cyc = 0, tx_pulses = 0, rx_pulses = 0, both = 0, longp = 0, oe_cnt = 0;
  int tx_last = 0;
  int plog[$];
  logic tx_prev = 1'b0, rx_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_req) begin tx_pulses++; tx_last = cyc; plog.push_back(0); end
      if (rx_req) begin rx_pulses++; plog.push_back(1); end
      if (tx_req && rx_req) both++;
      if ((tx_req && tx_prev) || (rx_req && rx_prev)) longp++;
      if (sda_oe) oe_cnt++;
    end
    tx_prev = tx_req;
    rx_prev = rx_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int last_rise = 0;

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_clk(input logic b, input logic glitch, output logic smp);
    if (glitch) begin
      ticks(3); scl_m = 1'b1; ticks(2); scl_m = 1'b0; ticks(5);
    end else begin
      ticks(10);
    end
    sda_m = b;
    ticks(10);
    scl_m = 1'b1;
    last_rise = cyc;
    ticks(10);
    smp = sda_line;
    ticks(10);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    ticks(10); sda_m = 1'b1;
    ticks(10); scl_m = 1'b1;
    ticks(10); sda_m = 1'b0;
    ticks(10); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    ticks(10); sda_m = 1'b0;
    ticks(10); scl_m = 1'b1;
    ticks(10); sda_m = 1'b1;
    ticks(20);
  endtask

  int rise8 = 0;

  task automatic write_byte(input logic [7:0] b, input int gl_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], gl_bit == i, s);
    rise8 = last_rise;
    bit_clk(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_clk(ack_bit, 1'b0, s);
  endtask

  logic [7:0] wq[$];

  task automatic wr_xact(input logic [1:0] r, input int gl_byte);
    logic a;
    i2c_start();
    write_byte(8'h82, -1, a); chk("ack_addr", 32'(a), 0);
    write_byte({6'd0, r}, -1, a); chk("ack_reg", 32'(a), 0);
    m_ptr = r;
    foreach (wq[i]) begin
      write_byte(wq[i], (i == gl_byte) ? 4 : -1, a);
      chk("ack_data", 32'(a), 0);
      m_wr(wq[i]);
    end
    i2c_stop();
    chk("tx_gain", 32'(tx_gain), m_tx);
    chk("rx_gain", 32'(rx_gain), m_rx);
    chk("tx_pulses", tx_pulses, exp_txp);
    chk("rx_pulses", rx_pulses, exp_rxp);
  endtask

  task automatic rd_xact(input logic [1:0] r, input int n);
    logic a;
    logic [7:0] d;
    int oe0;
    i2c_start();
    write_byte(8'h82, -1, a); chk("ack_addr", 32'(a), 0);
    write_byte({6'd0, r}, -1, a); chk("ack_reg", 32'(a), 0);
    m_ptr = r;
    i2c_start();
    write_byte(8'h83, -1, a); chk("ack_raddr", 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      chk("rdata", 32'(d), m_rd());
      if (i != n - 1) m_ptr = (m_ptr + 1) % 4;
    end
    chk("oe_after_nack", 32'(sda_oe), 0);
    oe0 = oe_cnt;
    read_byte(1'b1, d);
    chk("ignore_no_drive", oe_cnt - oe0, 0);
    i2c_stop();
  endtask

  initial begin
    logic a, s;
    logic [7:0] d;
    int oe0, txp0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    ticks(3);
    chk("rst_oe", 32'(sda_oe), 0);
    chk("rst_tx", 32'(tx_gain), 0);
    chk("rst_rx", 32'(rx_gain), 0);
    chk("rst_req", 32'({tx_req, rx_req}), 0);
    rst = 1'b0;
    ticks(10);

    // Single write to tx gain, then check pulse latency from the raw 8th rise.
    wq = '{8'h07};
    wr_xact(2'd0, -1);
    chk("tx_pulse_latency", tx_last - rise8, 5);

    // Burst write: tx then rx, pulses in order and never together.
    plog.delete();
    wq = '{8'h0C, 8'h2A};
    wr_xact(2'd0, -1);
    chk("pulse_order_n", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("pulse_order_0", plog[0], 0);
      chk("pulse_order_1", plog[1], 1);
    end

    rd_xact(2'd1, 2);

    // Wrong address: no ACK, no drive, no register change.
    oe0 = oe_cnt;
    i2c_start();
    write_byte(8'h84, -1, a); chk("nack_wrong_addr", 32'(a), 1);
    write_byte(8'h00, -1, a);
    write_byte(8'h0F, -1, a);
    i2c_stop();
    chk("wrong_addr_oe", oe_cnt - oe0, 0);
    chk("wrong_addr_tx", 32'(tx_gain), m_tx);
    chk("wrong_addr_rx", 32'(rx_gain), m_rx);

    // SCL glitch in the middle of a data byte.
    wq = '{8'($urandom_range(0, 255))};
    wr_xact(2'd0, 0);

    // Abort after 5 data bits, then a fresh transaction to rx gain.
    txp0 = tx_pulses;
    i2c_start();
    write_byte(8'h82, -1, a);
    write_byte(8'h00, -1, a);
    for (int i = 0; i < 5; i++) bit_clk(1'($urandom_range(0, 1)), 1'b0, s);
    d = 8'($urandom_range(0, 255));
    i2c_start();
    write_byte(8'h82, -1, a); chk("abort_readdr_ack", 32'(a), 0);
    write_byte(8'h01, -1, a);
    m_ptr = 1;
    write_byte(d, -1, a);
    m_wr(d);
    i2c_stop();
    chk("abort_no_tx_pulse", tx_pulses - txp0, 0);
    chk("abort_tx", 32'(tx_gain), m_tx);
    chk("abort_rx", 32'(rx_gain), m_rx);
    chk("abort_rx_pulses", rx_pulses, exp_rxp);

    // Randomised writes with readback of the whole map.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = $urandom_range(1, 4);
      wq.delete();
      for (int j = 0; j < n; j++) wq.push_back(8'($urandom_range(0, 255)));
      wr_xact(2'($urandom_range(0, 3)), -1);
      rd_xact(2'($urandom_range(0, 3)), 4);
    end

    // Reset while the slave is driving an ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'h82;
      bit_clk(ab[i], 1'b0, s);
    end
    ticks(10); sda_m = 1'b1; ticks(10); scl_m = 1'b1; ticks(5);
    chk("ack_before_rst", 32'(sda_oe), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_oe", 32'(sda_oe), 0);
    chk("midrst_tx", 32'(tx_gain), 0);
    chk("midrst_rx", 32'(rx_gain), 0);
    ticks(3);
    rst = 1'b0;
    m_tx = 0; m_rx = 0; m_ptr = 0;
    ticks(10); scl_m = 1'b0;
    i2c_stop();
    rd_xact(2'd0, 3);

    chk("pulses_same_cycle", both, 0);
    chk("pulse_width", longp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_gain_slave.md
# i2c_gain_slave

I2C target that receives host gain writes and produces `i2c_tx_gain_reg`, `i2c_rx_gain_reg` and the single-cycle update requests consumed by the AD9866 SPI sequencer. It sits directly upstream of that sequencer, in the same `clk` domain. It samples the open-drain SCL/SDA lines through synchronisers and a glitch filter. It supports register writes, and readback of the gain values plus an ID byte.

## Interface
- `I2C_ADDR`, 7'h41: 7-bit target address.
- `FILT`, 3: number of consecutive equal synchronised samples required before a filtered SCL/SDA level changes (1..15).
- `TX_GAIN_INIT`, 4'h0: reset value of the TX gain register.
- `RX_GAIN_INIT`, 6'h00: reset value of the RX gain register.
- `ID_BYTE`, 8'hA5: read-only value at register 0x02.

Ports:
- `clk` in 1: single clock; must be ≥ 20× SCL rate.
- `rst` in 1: synchronous, active-high reset.
- `scl_i` in 1: raw SCL pin level.
- `sda_i` in 1: raw SDA pin level.
- `sda_oe` out 1: 1 = drive SDA low; 0 = release.
- `i2c_tx_gain_reg` out 4: TX gain register (reg 0x00 bits [3:0]).
- `i2c_rx_gain_reg` out 6: RX gain register (reg 0x01 bits [5:0]).
- `i2c_tx_gain_update_req` out 1: one-`clk` pulse when reg 0x00 is written.
- `i2c_rx_gain_update_req` out 1: one-`clk` pulse when reg 0x01 is written.

## Operation
- Input path:
  - 2-FF synchroniser per line, then a filter counter per line.
  - The filtered level flips after `FILT` consecutive samples that differ from the current filtered level.
  - Rise/fall strobes are derived from the filtered levels.
- Bus conditions (all on filtered levels):
  - START/repeated START = SDA fall while SCL high. From any state → ADDR; bit counter cleared.
  - STOP = SDA rise while SCL high. From any state → IDLE; `sda_oe` released.
- State machine: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bit transfer:
  - Bits are sampled on SCL rise, MSB first.
  - The 8th rise completes a byte.
  - `sda_oe` changes only on the SCL fall that follows.
- ADDR:
  - On a byte whose [7:1] == `I2C_ADDR`, go to ADDR_ACK and assert `sda_oe` for the 9th clock.
  - On mismatch, go to IGNORE and never drive SDA until the next START.
  - R/W bit = 0 → REG after the ACK; R/W bit = 1 → RDATA after the ACK, loading the byte at the current pointer.
- REG: the byte is stored as pointer[1:0]; upper bits are ignored. ACK, then → WDATA.
- WDATA: on byte complete, write the register addressed by the pointer, then ACK, pointer+1 (wraps 3→0), → WDATA. Per register:
  - 0x00: tx gain ← data[3:0]; `i2c_tx_gain_update_req` pulses the same `clk` the register updates.
  - 0x01: rx gain ← data[5:0]; `i2c_rx_gain_update_req` pulses likewise.
  - 0x02, 0x03: write discarded, still ACKed, no pulse.
- RDATA:
  - Read map: 0x00 = {4'h0, tx}; 0x01 = {2'b00, rx}; 0x02 = `ID_BYTE`; 0x03 = 8'h00.
  - Each bit is presented on SCL fall: `sda_oe` = ~bit.
  - After the 8th bit, release SDA for the master ACK.
- RDATA_ACK: sample SDA on the 9th SCL rise.
  - Low (ACK): pointer+1, load the next byte → RDATA.
  - High (NACK): → IGNORE until STOP/START.
- The pointer persists across transactions, so a repeated-START read returns from the last written pointer.
- Gain registers change only on completed write bytes. A START/STOP mid-byte discards the partial byte; no pulse.

## Timing
- Reset values: `sda_oe`=0, tx gain=`TX_GAIN_INIT`, rx gain=`RX_GAIN_INIT`, both req=0, pointer=0, state IDLE, filtered SCL/SDA=1.
- Pin-to-edge latency: 2 sync cycles + `FILT` cycles (5 `clk` at default).
- Update pulse: exactly 1 `clk` wide, asserted `2+FILT` cycles after the raw 8th SCL rise of the data byte.
- Sequential writes to regs 0x00 then 0x01 give two separate pulses, one per byte, never in the same cycle.
- `rst` asserted mid-transaction: state goes to IDLE and `sda_oe` to 0 on the next `clk`, with registers at their init values.
- SCL glitches shorter than `FILT` `clk` cycles produce no edge.

## Test plan
- Reset: hold `rst` 3 cycles → `sda_oe`=0, tx=0x0, rx=0x00, no req pulses.
- Write S 0x82 A 0x00 A 0x07 A P → tx=0x7; one `i2c_tx_gain_update_req` pulse; ACK driven low on the 3 ninth clocks; rx unchanged.
- Burst write S 0x82, 0x00, 0x0C, 0x2A, P → tx=0xC then rx=0x2A, one pulse each, in order.
- Readback S 0x82 0x01 Sr 0x83 → master reads 0x2A then 0xA5 (ACK), NACK → SDA released, IGNORE until STOP.
- Wrong address S 0x84 … P → `sda_oe` never asserted; no register change.
- Glitch and abort:
  - A 2-cycle SCL pulse during a data byte → ignored.
  - A START after 5 data bits → partial byte discarded, no pulse, new ADDR phase decoded correctly.
